period_meter: RTL

//  Measures the period of a slow, asynchronous square-wave input, such as a divided clock
//  or an external strobe, in cycles of the system clock.

---
 rtl/period_meter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// Measures the period of a slow asynchronous square wave in Clk cycles.
// Optional duty measurement (HighTime) is built only when PERIOD_METER_DUTY_EN is defined.
module period_meter #(
  parameter int CntWidth   = 27,
  parameter int TimeoutVal = 100000000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                SigIn,
  output logic [CntWidth-1:0] Period,
  output logic [CntWidth-1:0] HighTime,
  output logic                Valid,
  output logic                Timeout,
  output logic                Measuring
);

  localparam logic [CntWidth-1:0] TIMEOUT_CNT = CntWidth'(TimeoutVal);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic s1;
  logic s2;
  logic s3;
  logic rise;

  logic start;
  logic capture;
  logic expire;

  logic [CntWidth-1:0] cnt;

  // s1/s2 form the metastability synchroniser; s3 is the edge-detect history.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= SigIn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEAS;
        end
      end
      MEAS: begin
        if (!rise && (cnt == TIMEOUT_CNT)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A rise always beats the timeout compare, so an edge landing exactly on
  // TimeoutVal still yields a valid measurement.
  always_comb begin
    start     = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    Measuring = 1'b0;
    case (state)
      IDLE: begin
        start = rise;
      end
      MEAS: begin
        Measuring = 1'b1;
        if (rise) begin
          capture = 1'b1;
        end else if (cnt == TIMEOUT_CNT) begin
          expire = 1'b1;
        end
      end
      default: begin
        start = 1'b0;
      end
    endcase
  end

  // Valid is a one-cycle strobe with no back-pressure: the consumer must take
  // Period/HighTime in the cycle Valid is high; they hold until the next strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt     <= '0;
      Period  <= '0;
      Valid   <= 1'b0;
      Timeout <= 1'b0;
    end else begin
      Valid <= capture;
      if (start) begin
        cnt <= CntWidth'(1);
      end else if (capture) begin
        Period  <= cnt;
        Timeout <= 1'b0;
        cnt     <= CntWidth'(1);
      end else if (expire) begin
        Timeout <= 1'b1;
        cnt     <= '0;
      end else if (state == MEAS) begin
        cnt <= cnt + CntWidth'(1);
      end
    end
  end

`ifdef PERIOD_METER_DUTY_EN
  logic [CntWidth-1:0] hi_cnt;
  logic [CntWidth-1:0] high_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_cnt <= '0;
      high_q <= '0;
    end else begin
      if (start) begin
        hi_cnt <= CntWidth'(1);
      end else if (capture) begin
        high_q <= hi_cnt;
        hi_cnt <= CntWidth'(1);
      end else if (expire) begin
        hi_cnt <= '0;
      end else if (state == MEAS) begin
        hi_cnt <= hi_cnt + CntWidth'(s2);
      end
    end
  end

  assign HighTime = high_q;
`else
  assign HighTime = '0;
`endif

endmodule
